// File: rtl/cond_pkg.sv
// Shared encodings for the condition-evaluation block: condition codes and flag bit positions.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FlagWidth = 4;

  // Signed-compare helper: true when N and V agree (GE sense).
  function automatic logic flags_ge(input logic [FlagWidth-1:0] flags);
    return flags[FLAG_N] == flags[FLAG_V];
  endfunction

endpackage

// File: rtl/cond_check.sv
// Pure combinational condition evaluator: decodes a 4-bit condition field against stored flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;

  assign w_n  = Flags[FLAG_N];
  assign w_z  = Flags[FLAG_Z];
  assign w_c  = Flags[FLAG_C];
  assign w_v  = Flags[FLAG_V];
  assign w_ge = flags_ge(Flags);

  always_comb begin
    CondEx = 1'b0;
    case (cond_t'(Cond))
      COND_EQ: CondEx = w_z;
      COND_NE: CondEx = ~w_z;
      COND_CS: CondEx = w_c;
      COND_CC: CondEx = ~w_c;
      COND_MI: CondEx = w_n;
      COND_PL: CondEx = ~w_n;
      COND_VS: CondEx = w_v;
      COND_VC: CondEx = ~w_v;
      COND_HI: CondEx = w_c & ~w_z;
      COND_LS: CondEx = ~w_c | w_z;
      COND_GE: CondEx = w_ge;
      COND_LT: CondEx = ~w_ge;
      COND_GT: CondEx = ~w_z & w_ge;
      COND_LE: CondEx = w_z | ~w_ge;
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Status-flag register, condition evaluation and write-strobe gating.
// Optional shadow flag register with save/restore enabled by COND_SHADOW_FLAGS_EN.
module cond_logic
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
`ifdef COND_SHADOW_FLAGS_EN
  input  logic       flag_save,
  input  logic       flag_restore,
`endif
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [3:0] r_flags;
  logic [3:0] w_flags_d;
  logic       w_cond_ex;
  logic       w_fire;
  logic       w_wr_nz;
  logic       w_wr_cv;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (r_flags),
    .CondEx (w_cond_ex)
  );

  // en is the leading term so an unknown condition never reaches state while stalled.
  assign w_fire  = en & w_cond_ex;
  assign w_wr_nz = w_fire & FlagW[1];
  assign w_wr_cv = w_fire & FlagW[0];

`ifdef COND_SHADOW_FLAGS_EN
  logic [3:0] r_shadow;
  logic       w_save;
  logic       w_restore;

  assign w_save    = en & flag_save;
  assign w_restore = en & flag_restore;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= 4'b0000;
    end else if (w_save) begin
      r_shadow <= r_flags;
    end
  end
`endif

  always_comb begin
    w_flags_d = r_flags;
    if (w_wr_nz) begin
      w_flags_d[FLAG_N] = ALUFlags[FLAG_N];
      w_flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (w_wr_cv) begin
      w_flags_d[FLAG_C] = ALUFlags[FLAG_C];
      w_flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
`ifdef COND_SHADOW_FLAGS_EN
    // Restore wins over any ALU flag write in the same cycle.
    if (w_restore) begin
      w_flags_d = r_shadow;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else begin
      r_flags <= w_flags_d;
    end
  end

  assign CondEx   = w_cond_ex;
  assign Flags    = r_flags;
  assign PCSrc    = w_fire & PCS;
  assign RegWrite = w_fire & RegW & ~NoWrite;
  assign MemWrite = w_fire & MemW;

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic; shadow tests built with COND_SHADOW_FLAGS_EN.
module tb_cond_logic;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       flag_save;
  logic       flag_restore;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  int n_vec;
  int n_err;

  cond_logic dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .Cond         (Cond),
    .ALUFlags     (ALUFlags),
    .FlagW        (FlagW),
    .PCS          (PCS),
    .RegW         (RegW),
    .MemW         (MemW),
    .NoWrite      (NoWrite),
`ifdef COND_SHADOW_FLAGS_EN
    .flag_save    (flag_save),
    .flag_restore (flag_restore),
`endif
    .PCSrc        (PCSrc),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .CondEx       (CondEx),
    .Flags        (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    flag_save = 1'b0; flag_restore = 1'b0;
  endtask

  // Load flags through an unconditional full write.
  task automatic load_flags(input logic [3:0] v);
    idle();
    Cond = 4'hE; FlagW = 2'b11; ALUFlags = v;
    tick();
    FlagW = 2'b00;
  endtask

  // Expected CondEx for Cond 0..15 (bit i = code i), hand-derived per flag value.
  task automatic sweep(input string tag, input logic [3:0] f, input logic [15:0] exp_mask);
    logic [15:0] got;
    load_flags(f);
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i);
      #1;
      got[i] = CondEx;
    end
    check(tag, got, exp_mask);
    en = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;
    #12;
    check("reset_flags", 16'(Flags), 16'h0);
    rst_n = 1'b1;
    tick();

    // Reset flags: EQ fails, AL passes.
    Cond = 4'h0; RegW = 1'b1;
    #1;
    check("rst_eq_condex", 16'(CondEx), 16'h0);
    check("rst_eq_regwrite", 16'(RegWrite), 16'h0);
    Cond = 4'hE;
    #1;
    check("rst_al_regwrite", 16'(RegWrite), 16'h1);

    // Back-to-back: Z written in one cycle conditions the next.
    idle();
    ALUFlags = 4'b0100; FlagW = 2'b11;
    tick();
    idle();
    Cond = 4'h0; MemW = 1'b1;
    #1;
    check("b2b_flags", 16'(Flags), 16'h4);
    check("b2b_memwrite", 16'(MemWrite), 16'h1);

    // Independent half updates.
    load_flags(4'b0000);
    FlagW = 2'b10; ALUFlags = 4'b1111;
    tick();
    check("half_nz", 16'(Flags), 16'hC);
    FlagW = 2'b01; ALUFlags = 4'b0011;
    tick();
    check("half_cv", 16'(Flags), 16'hF);

    // Failed condition: no flag write, no strobes.
    load_flags(4'b1000);
    Cond = 4'hA; FlagW = 2'b11; ALUFlags = 4'b0000; MemW = 1'b1; PCS = 1'b1;
    #1;
    check("ge_condex", 16'(CondEx), 16'h0);
    check("ge_strobes", {13'h0, PCSrc, RegWrite, MemWrite}, 16'h0);
    tick();
    check("ge_flags_kept", 16'(Flags), 16'h8);
    Cond = 4'hB; FlagW = 2'b00;
    #1;
    check("lt_condex", 16'(CondEx), 16'h1);
    check("lt_pcsrc", 16'(PCSrc), 16'h1);

    // NoWrite blocks only RegWrite.
    idle();
    NoWrite = 1'b1; RegW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0101;
    #1;
    check("nowrite_strobes", {13'h0, PCSrc, RegWrite, MemWrite}, 16'h4);
    tick();
    check("nowrite_flags", 16'(Flags), 16'h5);

    // Stalled: nothing written, strobes low, CondEx still live.
    en = 1'b0; NoWrite = 1'b0; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; ALUFlags = 4'b1010;
    #1;
    check("stall_strobes", {13'h0, PCSrc, RegWrite, MemWrite}, 16'h0);
    check("stall_condex", 16'(CondEx), 16'h1);
    tick();
    check("stall_flags", 16'(Flags), 16'h5);

    sweep("sweep_0101", 4'b0101, 16'h6A69);
    sweep("sweep_1010", 4'b1010, 16'h6996);
    sweep("sweep_1001", 4'b1001, 16'h565A);
    sweep("sweep_0110", 4'b0110, 16'h66A5);

    // Mid-stream asynchronous reset.
    load_flags(4'b0100);
    Cond = 4'h0; RegW = 1'b1;
    #2;
    check("pre_rst_regwrite", 16'(RegWrite), 16'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", 16'(Flags), 16'h0);
    check("mid_rst_regwrite", 16'(RegWrite), 16'h0);
    #3;
    rst_n = 1'b1;
    tick();

`ifdef COND_SHADOW_FLAGS_EN
    load_flags(4'b0110);
    flag_save = 1'b1;
    tick();
    flag_save = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1001;
    tick();
    check("sh_written", 16'(Flags), 16'h9);
    flag_restore = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
    tick();
    check("sh_restore", 16'(Flags), 16'h6);
    // Swap: flags 1001 / shadow 0110 exchange.
    idle();
    FlagW = 2'b11; ALUFlags = 4'b1001;
    tick();
    idle();
    flag_save = 1'b1; flag_restore = 1'b1;
    tick();
    check("sh_swap_flags", 16'(Flags), 16'h6);
    idle();
    flag_restore = 1'b1;
    tick();
    check("sh_swap_shadow", 16'(Flags), 16'h9);
    // Stalled restore does nothing.
    idle();
    en = 1'b0; flag_restore = 1'b1;
    tick();
    check("sh_stall_restore", 16'(Flags), 16'h9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
